credit_recouple: RTL and testbench

- Receive end of a credit-flow-controlled link whose transmit end converts a dti stream into valid+data with no ready.
- Buffers incoming words in a DEPTH-entry FIFO and presents them on a dti producer interface.
- Returns one credit pulse per word drained, so the transmitter never sends more than DEPTH words outstanding.
- Used where a registered link, or a link that crosses a long route, cannot carry a combinational ready back to the sender.

---
 rtl/credit_recouple_if.sv | 10 +
 rtl/credit_recouple.sv | 70 +++++++
 tb/tb_credit_recouple.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/credit_recouple_if.sv
// dti: valid/ready/data stream interface used on the drain side of credit_recouple.
interface dti #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    modport producer(output valid, output data, input ready);
    modport consumer(input valid, input data, output ready);
endinterface

// File: rtl/credit_recouple.sv
// credit_recouple: receive end of a credit link; buffers words and returns one credit per drained word.
module credit_recouple #(
    parameter int DEPTH          = 4,
    parameter bit OPT_ERR_STICKY = 1,
    parameter int W              = 16,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          link_valid,
    input  logic [W-1:0]  link_data,
    output logic          link_credit,
    dti.producer          dout,
    output logic          err,
    output logic [AW:0]   level
);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d, fptr_q, fptr_d;
    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d, credit_q, credit_d, err_q, err_d;
    logic         pop, push, avail, fetch;

    // fptr marks the next word to move into the output register; the register's
    // word keeps its slot (between rptr and fptr) until it is handshaken
    always_comb begin
        pop      = valid_q && dout.ready;
        push     = link_valid && ((wptr_q - rptr_q) != FULL || pop);
        avail    = (fptr_q != wptr_q) || push;
        fetch    = (!valid_q || dout.ready) && avail;
        wptr_d   = wptr_q + {{AW{1'b0}}, push};
        rptr_d   = rptr_q + {{AW{1'b0}}, pop};
        fptr_d   = fptr_q + {{AW{1'b0}}, fetch};
        valid_d  = fetch || (valid_q && !dout.ready);
        data_d   = !fetch ? data_q : (fptr_q == wptr_q) ? link_data : mem_q[fptr_q[AW-1:0]];
        credit_d = pop;
        err_d    = (link_valid && !push) || (OPT_ERR_STICKY && err_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            fptr_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            credit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fptr_q   <= fptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= link_data;
    end

    assign dout.valid  = valid_q;
    assign dout.data   = data_q;
    assign link_credit = credit_q;
    assign err         = err_q;
    assign level       = wptr_q - rptr_q;
endmodule

// File: tb/tb_credit_recouple.sv
// tb_credit_recouple: scoreboard bench with a credit-holding transmitter model.
module tb_credit_recouple;
    localparam int D = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         link_valid;
    logic [W-1:0] link_data;
    logic         link_credit;
    logic         err;
    logic [2:0]   level;

    dti #(.W(W)) dout ();

    credit_recouple #(.DEPTH(D), .OPT_ERR_STICKY(1), .W(W)) dut (
        .clk(clk), .rst(rst), .link_valid(link_valid), .link_data(link_data),
        .link_credit(link_credit), .dout(dout), .err(err), .level(level)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [W-1:0] expq[$];
    int lvl_m, credits, hs_cnt, cr_cnt;
    bit hs_prev, err_m, tx_mode, hs, push;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hs   = dout.valid && dout.ready;
            push = link_valid && (lvl_m < D || hs);
            chk("level", level, lvl_m);
            chk("credit", link_credit, hs_prev);
            chk("err", err, err_m);
            if (tx_mode) chk("invariant", level + credits + link_valid, D);
            if (hs) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h want none at %0t", dout.data, $time);
                end else chk("data", dout.data, expq.pop_front());
                hs_cnt++;
            end
            if (link_credit) cr_cnt++;
            lvl_m   = lvl_m + int'(push) - int'(hs);
            err_m   = err_m || (link_valid && !push);
            hs_prev = hs;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit acc);
        link_valid = v;
        link_data  = d;
        if (v && acc) expq.push_back(d);
    endtask

    task automatic clear_model();
        expq.delete();
        lvl_m   = 0;
        hs_prev = 0;
        err_m   = 0;
    endtask

    task automatic do_reset();
        tx_mode = 0;
        rst = 1'b0;
        drive(0, '0, 0);
        dout.ready = 1'b0;
        clear_model();
        cyc();
        chk("rst_valid", dout.valid, 0);
        chk("rst_credit", link_credit, 0);
        chk("rst_level", level, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
    endtask

    task automatic drain();
        drive(0, '0, 0);
        dout.ready = 1'b1;
        for (int i = 0; i < 200 && (expq.size() != 0 || level != 0); i++) cyc();
        cyc();
        chk("drained_q", expq.size(), 0);
        chk("drained_level", level, 0);
    endtask

    initial begin
        int h0, c0;
        do_reset();
        // single word latency and credit timing
        dout.ready = 1'b1;
        drive(1, 16'h00A5, 1);
        cyc();
        drive(0, '0, 0);
        chk("lat_valid", dout.valid, 1);
        chk("lat_data", dout.data, 16'h00A5);
        cyc();
        chk("lat_credit1", link_credit, 1);
        cyc();
        chk("lat_credit0", link_credit, 0);
        // fill with ready low
        dout.ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, W'(i), 1);
            cyc();
        end
        drive(0, '0, 0);
        cyc();
        chk("fill_level", level, 4);
        chk("fill_err", err, 0);
        chk("fill_hold", dout.data, 1);
        // overflow with ready low
        drive(1, 16'h0055, 0);
        cyc();
        drive(0, '0, 0);
        chk("ovf_err", err, 1);
        chk("ovf_level", level, 4);
        cyc();
        chk("ovf_sticky", err, 1);
        chk("ovf_hold", dout.data, 1);
        // full with simultaneous push and pop
        dout.ready = 1'b1;
        drive(1, 16'd9, 1);
        cyc();
        drive(0, '0, 0);
        chk("pp_level", level, 4);
        drain();
        // streaming
        do_reset();
        dout.ready = 1'b1;
        h0 = hs_cnt;
        c0 = cr_cnt;
        for (int i = 0; i < 100; i++) begin
            drive(1, W'(16'h1000 + i), 1);
            cyc();
        end
        drain();
        repeat (2) cyc();
        chk("stream_outputs", hs_cnt - h0, 100);
        chk("stream_credits", cr_cnt - c0, 100);
        // random ready against a credit-respecting transmitter, reset mid-burst
        for (int r = 0; r < 2; r++) begin
            do_reset();
            credits = D;
            tx_mode = 1;
            for (int i = 0; i < 300; i++) begin
                cyc();
                if (link_credit) credits++;
                dout.ready = ($urandom % 3) != 0;
                if (credits > 0 && ($urandom % 4) != 0) begin
                    credits--;
                    drive(1, W'($urandom), 1);
                end else drive(0, '0, 0);
            end
            if (r == 0) begin
                #2;
                rst = 1'b0;
                #1;
                chk("async_valid", dout.valid, 0);
                chk("async_credit", link_credit, 0);
                chk("async_level", level, 0);
            end
        end
        tx_mode = 0;
        drain();
        chk("final_err", err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
